// File: rtl/branch_flag_unit_pkg.sv
// Shared definitions for the core_lapido branch/flag logic: condition codes,
// flag bit positions and the shadow state encoding.
package lapido_defs;

    localparam logic [2:0] COND_NEG     = 3'd0;
    localparam logic [2:0] COND_ZERO    = 3'd1;
    localparam logic [2:0] COND_CARRY   = 3'd2;
    localparam logic [2:0] COND_NEGZERO = 3'd3;
    localparam logic [2:0] COND_TRUE    = 3'd4;
    localparam logic [2:0] COND_OVF     = 3'd5;
    localparam logic [2:0] COND_ALWAYS  = 3'd6;
    localparam logic [2:0] COND_RSVD    = 3'd7;

    localparam int unsigned FL_ZERO    = 0;
    localparam int unsigned FL_TRUE    = 1;
    localparam int unsigned FL_NEG     = 2;
    localparam int unsigned FL_OVF     = 3;
    localparam int unsigned FL_NEGZERO = 4;
    localparam int unsigned FL_CARRY   = 5;
    localparam int unsigned FL_W       = 6;

    localparam logic [0:0] SH_EMPTY = 1'b0;
    localparam logic [0:0] SH_FULL  = 1'b1;

endpackage

// File: rtl/branch_flag_unit_if.sv
// ALU flag inputs, shadow controls, branch request and result signals
// exchanged with branch_flag_unit.
interface branch_flag_unit_if #(parameter int unsigned CNT_W = 16);

    logic             alu_carry;
    logic [4:0]       alu_flags;
    logic             flags_we;
    logic             flags_save;
    logic             flags_restore;
    logic             br_valid;
    logic [2:0]       br_cond;
    logic             br_pol;
    logic             taken_valid;
    logic             taken;
    logic [5:0]       flags_q;
    logic             shadow_full;
    logic             restore_err;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output alu_carry, alu_flags, flags_we, flags_save, flags_restore,
               br_valid, br_cond, br_pol,
        input  taken_valid, taken, flags_q, shadow_full, restore_err, taken_count
    );

    modport slave (
        input  alu_carry, alu_flags, flags_we, flags_save, flags_restore,
               br_valid, br_cond, br_pol,
        output taken_valid, taken, flags_q, shadow_full, restore_err, taken_count
    );

endinterface

// File: rtl/branch_flag_unit_cond.sv
// Combinational branch decision from forwarded flags, condition code and polarity.
module branch_cond_eval
    import lapido_defs::*;
(
    input  logic [5:0] ff_i,
    input  logic [2:0] cond_i,
    input  logic       pol_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_NEG:     taken_o = (ff_i[FL_NEG]     == pol_i);
            COND_ZERO:    taken_o = (ff_i[FL_ZERO]    == pol_i);
            COND_CARRY:   taken_o = (ff_i[FL_CARRY]   == pol_i);
            COND_NEGZERO: taken_o = (ff_i[FL_NEGZERO] == pol_i);
            COND_TRUE:    taken_o = (ff_i[FL_TRUE]    == pol_i);
            COND_OVF:     taken_o = (ff_i[FL_OVF]     == pol_i);
            COND_ALWAYS:  taken_o = 1'b1;
            default:      taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_flag_unit.sv
// Architectural flag register with one-entry shadow, forwarded-flag branch
// evaluation (one-cycle registered result) and a saturating taken counter.
module branch_flag_unit
    import lapido_defs::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_flag_unit_if.slave  bus
);

    logic [FL_W-1:0]  flag_reg_q, flag_reg_d;
    logic [FL_W-1:0]  shadow_q, shadow_d;
    logic [0:0]       sh_state_q, sh_state_d;
    logic             restore_err_q, restore_err_d;
    logic             taken_valid_q;
    logic             taken_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             restore_ok;
    logic [FL_W-1:0]  ff;
    logic             taken_c;

    assign restore_ok = bus.flags_restore && (sh_state_q == SH_FULL);

    // Forwarded flags double as the flag register's next value.
    always_comb begin
        if (restore_ok)
            ff = shadow_q;
        else if (bus.flags_we)
            ff = {bus.alu_carry, bus.alu_flags};
        else
            ff = flag_reg_q;
    end

    assign flag_reg_d    = ff;
    assign restore_err_d = bus.flags_restore && (sh_state_q == SH_EMPTY);

    // Any restore request suppresses a simultaneous save.
    always_comb begin
        shadow_d   = shadow_q;
        sh_state_d = sh_state_q;
        if (restore_ok) begin
            sh_state_d = SH_EMPTY;
        end else if (bus.flags_save && !bus.flags_restore) begin
            shadow_d   = flag_reg_q;
            sh_state_d = SH_FULL;
        end
    end

    branch_cond_eval u_eval (
        .ff_i    (ff),
        .cond_i  (bus.br_cond),
        .pol_i   (bus.br_pol),
        .taken_o (taken_c)
    );

    always_comb begin
        count_d = count_q;
        if (bus.br_valid && taken_c && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_reg_q    <= '0;
            shadow_q      <= '0;
            sh_state_q    <= SH_EMPTY;
            restore_err_q <= 1'b0;
            taken_valid_q <= 1'b0;
            taken_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            flag_reg_q    <= flag_reg_d;
            shadow_q      <= shadow_d;
            sh_state_q    <= sh_state_d;
            restore_err_q <= restore_err_d;
            taken_valid_q <= bus.br_valid;
            if (bus.br_valid)
                taken_q <= taken_c;
            count_q       <= count_d;
        end
    end

    assign bus.flags_q     = flag_reg_q;
    assign bus.shadow_full = (sh_state_q == SH_FULL);
    assign bus.restore_err = restore_err_q;
    assign bus.taken_valid = taken_valid_q;
    assign bus.taken       = taken_q;
    assign bus.taken_count = count_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed plus randomized checks of branch_flag_unit against a cycle model.
module tb_branch_flag_unit;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_flag_unit_if #(.CNT_W(CW)) bus();

    branch_flag_unit #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    logic [5:0] m_flags;
    logic [5:0] m_shadow;
    logic       m_full;
    logic       m_err;
    logic       m_tv;
    logic       m_taken;
    int         m_cnt;
    // flag bit selected by condition codes 0..5: neg, zero, carry, negzero, true, ovf
    int         sel [6] = '{2, 0, 5, 4, 1, 3};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alu_carry     = 1'b0;
        bus.alu_flags     = '0;
        bus.flags_we      = 1'b0;
        bus.flags_save    = 1'b0;
        bus.flags_restore = 1'b0;
        bus.br_valid      = 1'b0;
        bus.br_cond       = '0;
        bus.br_pol        = 1'b0;
    endtask

    function automatic logic decide(input logic [5:0] f, input logic [2:0] cond, input logic pol);
        int c;
        c = int'(cond);
        if (c == 6) return 1'b1;
        if (c == 7) return 1'b0;
        return (f[sel[c]] == pol);
    endfunction

    task automatic tick();
        logic [5:0] alu;
        logic [5:0] fwd;
        logic       ok;
        alu = {bus.alu_carry, bus.alu_flags};
        @(posedge clk);
        if (rst) begin
            m_flags = '0; m_shadow = '0; m_full = 0; m_err = 0;
            m_tv = 0; m_taken = 0; m_cnt = 0;
        end else begin
            ok  = bus.flags_restore && m_full;
            fwd = ok ? m_shadow : (bus.flags_we ? alu : m_flags);
            m_err = bus.flags_restore && !m_full;
            if (ok) m_full = 0;
            else if (bus.flags_save && !bus.flags_restore) begin
                m_shadow = m_flags;
                m_full   = 1;
            end
            m_tv = bus.br_valid;
            if (bus.br_valid) begin
                m_taken = decide(fwd, bus.br_cond, bus.br_pol);
                if (m_taken && m_cnt < CMAX) m_cnt++;
            end
            m_flags = fwd;
        end
        #1;
        chk("flags_q", 16'(bus.flags_q), 16'(m_flags));
        chk("shadow_full", 16'(bus.shadow_full), 16'(m_full));
        chk("restore_err", 16'(bus.restore_err), 16'(m_err));
        chk("taken_valid", 16'(bus.taken_valid), 16'(m_tv));
        if (m_tv) chk("taken", 16'(bus.taken), 16'(m_taken));
        chk("taken_count", 16'(bus.taken_count), 16'(m_cnt));
    endtask

    initial begin
        idle();
        m_flags = '0; m_shadow = '0; m_full = 0; m_err = 0;
        m_tv = 0; m_taken = 0; m_cnt = 0;

        // reset
        rst = 1'b1; tick(); tick();
        chk("reset_flags", 16'(bus.flags_q), 16'h0);
        rst = 1'b0;

        // 1: write then branch on zero
        bus.flags_we = 1; bus.alu_flags = 5'b10001; tick();
        chk("t1_flags", 16'(bus.flags_q), 16'h11);
        idle(); bus.br_valid = 1; bus.br_cond = 3'd1; bus.br_pol = 1; tick();
        chk("t1_taken", {14'b0, bus.taken_valid, bus.taken}, 16'h3);

        // 2: same-cycle forwarding
        idle(); bus.flags_we = 1; bus.alu_flags = 5'b00000; tick();
        idle(); bus.flags_we = 1; bus.alu_flags = 5'b00001;
        bus.br_valid = 1; bus.br_cond = 3'd1; bus.br_pol = 0; tick();
        chk("t2_fwd", {14'b0, bus.taken_valid, bus.taken}, 16'h2);

        // 3: save / write / restore
        idle(); bus.flags_we = 1; bus.alu_carry = 1; bus.alu_flags = 5'b00010; tick();
        idle(); bus.flags_save = 1; tick();
        chk("t3_full", 16'(bus.shadow_full), 16'h1);
        idle(); bus.flags_we = 1; bus.alu_flags = 5'b00001; tick();
        idle(); bus.flags_restore = 1; tick();
        chk("t3_restored", {9'b0, bus.shadow_full, bus.flags_q}, 16'h22);

        // 4: illegal restore with write, then save+restore while full
        idle(); bus.flags_restore = 1; bus.flags_we = 1; bus.alu_flags = 5'b01000; tick();
        chk("t4_err", {9'b0, bus.restore_err, bus.flags_q}, 16'h48);
        idle(); tick();
        chk("t4_err_pulse", 16'(bus.restore_err), 16'h0);
        bus.flags_save = 1; tick();
        idle(); bus.flags_we = 1; bus.alu_flags = 5'b00100; tick();
        idle(); bus.flags_save = 1; bus.flags_restore = 1; tick();
        chk("t4_sv_rs", {9'b0, bus.shadow_full, bus.flags_q}, 16'h08);

        // 5: unconditional and reserved
        idle(); bus.br_valid = 1; bus.br_cond = 3'd6; bus.br_pol = 0; tick();
        chk("t5_always", 16'(bus.taken), 16'h1);
        bus.br_cond = 3'd7; bus.br_pol = 1; tick();
        chk("t5_rsvd", 16'(bus.taken), 16'h0);

        // 6: saturation
        idle(); bus.br_valid = 1; bus.br_cond = 3'd6;
        for (int i = 0; i < 20; i++) tick();
        chk("t6_sat", 16'(bus.taken_count), 16'(CMAX));

        // 6: reset with a branch in flight
        idle(); bus.br_valid = 1; bus.br_cond = 3'd6; bus.flags_we = 1;
        bus.alu_flags = 5'h1f; bus.flags_save = 1; tick();
        rst = 1; idle(); bus.flags_restore = 1; tick();
        chk("t6_rst", {8'b0, bus.taken_valid, bus.restore_err, bus.shadow_full,
                       bus.taken_count, bus.taken}, 16'h0);
        chk("t6_rst_flags", 16'(bus.flags_q), 16'h0);
        rst = 0;

        // randomized
        for (int i = 0; i < 400; i++) begin
            bus.alu_carry     = 1'($urandom);
            bus.alu_flags     = 5'($urandom);
            bus.flags_we      = ($urandom_range(0, 2) != 0);
            bus.flags_save    = ($urandom_range(0, 4) == 0);
            bus.flags_restore = ($urandom_range(0, 4) == 0);
            bus.br_valid      = ($urandom_range(0, 2) != 0);
            bus.br_cond       = 3'($urandom);
            bus.br_pol        = 1'($urandom);
            rst               = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0; idle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_flag_unit.md
# branch_flag_unit

Consumes the carry and status flags produced by the ALU and decides conditional jumps for the core_lapido pipeline. Holds the architectural flag register, a one-entry interrupt shadow copy with save/restore, and a saturating taken-branch counter. Branch requests are evaluated against forwarded flags, so a branch issued in the same cycle as the flag-setting instruction sees that instruction's flags. The result is registered and returned one cycle later.

## Interface
- `CNT_W`, 16, width of the taken-branch counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `alu_carry`  in  1  ALU result bit 32, the carry.
- `alu_flags`  in  5  ALU flags: [0] zero, [1] true, [2] neg, [3] overflow, [4] negzero.
- `flags_we`  in  1  write `{alu_carry, alu_flags}` into the flag register.
- `flags_save`  in  1  copy the flag register into the shadow.
- `flags_restore`  in  1  load the flag register from the shadow.
- `br_valid`  in  1  branch request.
- `br_cond`  in  3  condition select (see Operation).
- `br_pol`  in  1  1 = jump if true (jt.*), 0 = jump if false (jf.*).
- `taken_valid`  out  1  result strobe, one cycle wide.
- `taken`  out  1  branch taken; meaningful only while `taken_valid` is high.
- `flags_q`  out  6  flag register `{carry, negzero, overflow, neg, true, zero}`.
- `shadow_full`  out  1  shadow holds a saved value.
- `restore_err`  out  1  one-cycle pulse when a restore is requested while the shadow is empty.
- `taken_count`  out  CNT_W  saturating count of taken branches.

## Operation
**Reset.** While `rst` is high at a clock edge, every output and register goes to 0: `flags_q`, shadow, `shadow_full`, `taken_valid`, `taken`, `restore_err` and `taken_count`.

**Flag register next value.** Priority is restore > write > hold.
- Restore with the shadow full: `flags_q` takes the shadow value and the shadow becomes empty.
- Restore with the shadow empty: `flags_q` is unchanged, `restore_err` pulses, and `flags_we` is still honoured in that cycle.
- Otherwise, if `flags_we` is high, `flags_q` takes the ALU inputs.

**Shadow state machine.** Two states, EMPTY and FULL.
- A save in either state captures the pre-update `flags_q` and goes to FULL. A save in FULL overwrites the shadow.
- A valid restore goes to EMPTY.
- Save and restore in the same cycle: the restore wins and the save is ignored.
- `shadow_full` = (state == FULL).

**Forwarded flags `ff`.** Same priority as the flag register next value: shadow on a valid restore, else the ALU inputs when `flags_we` is high, else `flags_q`.

**Condition `c` from `br_cond`:**
- 0: `ff` neg
- 1: `ff` zero
- 2: `ff` carry
- 3: `ff` negzero
- 4: `ff` true
- 5: `ff` overflow
- 6: always (unconditional jump)
- 7: reserved, never taken

**Taken decision.**
- Codes 0–5: taken = (c == `br_pol`).
- Code 6: taken = 1 and `br_pol` is ignored.
- Code 7: taken = 0 and `br_pol` is ignored.

**Counter.** `taken_count` increments on each taken result and saturates at all ones. It does not wrap.

## Timing
- Branch latency: a request accepted at edge N (`br_valid` high) gives `taken_valid` = 1 with `taken` for the cycle after N. There is no backpressure, so a new branch can be accepted every cycle.
- `taken` holds its last value while `taken_valid` is low. The bench checks it only on the strobe.
- `flags_q`, the shadow, `shadow_full` and `restore_err` all update at the edge that samples their controls.
- `taken_count` updates at the same edge that raises `taken_valid`.
- Reset asserted while a branch is in flight: `taken_valid` is 0 in the next cycle and the in-flight result is lost.

## Structure
- Shared package `lapido_defs`: condition-code constants `COND_NEG` … `COND_RSVD`, flag bit indices (`FL_*` plus `FL_CARRY` = 5), and the shadow state encoding.
- One sub-module, `branch_cond_eval`: combinational mux of `ff`, `br_cond` and `br_pol` to `taken`. The top level holds the registers, the forwarding logic, the shadow state machine and the counter.

## Test plan
1. Write, then branch.
   - Stimulus: `flags_we`=1 with zero=1 (`alu_flags`=5'b10001); next cycle `br_valid`, `br_cond`=1, `br_pol`=1.
   - Required: `taken_valid`=1 and `taken`=1 in the following cycle; `flags_q`=6'b010001.
2. Same-cycle forwarding.
   - Stimulus: `flags_q` zero=0; in one cycle `flags_we`=1 with zero=1 and `br_valid`, `br_cond`=1, `br_pol`=0.
   - Required: `taken`=0, because the forwarded zero flag is used.
3. Save and restore.
   - Stimulus: `flags_q`=6'h22, save; then write 6'h01; then restore.
   - Required: `shadow_full` goes 1 then 0, and `flags_q` ends at 6'h22.
4. Illegal restore and simultaneous save/restore.
   - Stimulus: restore with the shadow EMPTY and `flags_we`=1.
   - Required: `restore_err` pulses for one cycle and the ALU flags are written.
   - Stimulus: save and restore together while FULL.
   - Required: shadow value restored and `shadow_full`=0.
5. Unconditional and reserved codes.
   - Stimulus: `br_cond`=6 with `br_pol`=0, then `br_cond`=7 with `br_pol`=1.
   - Required: `taken`=1, then `taken`=0.
6. Counter saturation and reset.
   - Stimulus: CNT_W=4, 20 back-to-back taken branches.
   - Required: `taken_count`=15 and held there.
   - Stimulus: `rst` asserted mid-stream.
   - Required: all outputs 0 at the next edge.
